msx_bus_initiator: RTL
======================

Name: msx_bus_initiator

Overview:
- Host-side MSX-50BUS cycle generator: the initiating end of the slot bus that cartridge responders (SCC/mapper/ROM/RAM wrappers) decode.
- Accepts single-byte read/write requests over a valid/ready handshake and drives n_tsltsl, n_trd, n_twr, ta and wdata with programmable setup/strobe/hold phases.
- Honours n_wait, samples rdata/rdata_en, and returns one response per request.
- Used as the bus master in cartridge test harnesses and in host-emulation builds.

Parameters:
- SETUP_CYC, 2: clocks with ta valid and n_tsltsl low before the strobe asserts. Range 1..255.
- STROBE_CYC, 4: minimum clocks with n_trd or n_twr low. Range 1..255.
- HOLD_CYC, 1: clocks after the strobe with ta/wdata held and n_tsltsl high. Range 1..255.

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&ready at a clk edge
- req_write  in  1  1 = write cycle, 0 = read cycle
- req_address  in  16  bus address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clock pulse, response present
- rsp_rdata  out  8  read data (0xFF on writes or when no responder drove the bus)
- rsp_hit  out  1  rdata_en was seen at the read sample point
- rsp_timeout  out  1  wait limit hit (see Optional Feature)
- n_tsltsl  out  1  slot select, active low
- n_trd  out  1  read strobe, active low
- n_twr  out  1  write strobe, active low
- ta  out  16  address bus
- wdata  out  8  write data bus
- rdata  in  8  responder read data
- rdata_en  in  1  responder drives rdata
- n_wait  in  1  responder wait request, active low; synchronous to clk

Behaviour:
- Reset values (applied asynchronously while reset=1): n_tsltsl=1, n_trd=1, n_twr=1, ta=0x0000, wdata=0x00, rsp_valid=0, rsp_rdata=0xFF, rsp_hit=0, rsp_timeout=0, state=IDLE.
- All bus outputs are registered; req_ready is 1 exactly when state=IDLE.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. An 8-bit down counter times each phase.
- IDLE: on valid&ready, latch the request; next clock ta=req_address, wdata=req_wdata (writes; wdata=0x00 on reads), n_tsltsl=0. Enter SETUP for SETUP_CYC clocks.
- STROBE: n_tsltsl=0 with n_trd=0 (read) or n_twr=0 (write), held for at least STROBE_CYC clocks. At the edge ending the last counted strobe clock:
  - If n_wait=0, extend by one clock and re-check each clock.
  - Otherwise, for reads: capture rdata into rsp_rdata if rdata_en=1, else capture 0xFF; set rsp_hit=rdata_en. Go to HOLD.
- HOLD: n_tsltsl=1, n_trd=1, n_twr=1; ta and wdata unchanged for HOLD_CYC clocks. Then go to IDLE with rsp_valid=1 for exactly that one IDLE clock.
- Back-to-back: a request may be accepted in the same clock that rsp_valid=1.
- Latency, with defaults and no wait: accept at edge 0, SETUP clocks 1-2, STROBE 3-6, HOLD 7, rsp_valid in clock 8. Bus period is 8 clocks per transfer.
- rsp_rdata, rsp_hit and rsp_timeout hold until the next response. For writes: rsp_rdata=0xFF, rsp_hit=0.
- ta and wdata hold their last values while idle; the strobes are never low while n_tsltsl=1.
- Reset mid-cycle: the bus releases immediately and no rsp_valid is issued for the aborted request.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro MSXBUS_WAIT_TIMEOUT_EN.
- Defined: wait extension is limited to 255 extra clocks. On expiry the strobe releases, the cycle proceeds to HOLD with rsp_timeout=1, rsp_rdata=0xFF and rsp_hit=0.
- Undefined: wait extends indefinitely and rsp_timeout is tied to 0.

Test Plan:
- Reset then write 0x7FFC<-0x83 (defaults) -> ta=0x7FFC and n_tsltsl=0 from clock 1; n_twr=0 in clocks 3-6 only; wdata=0x83; rsp_valid in clock 8 with rsp_rdata=0xFF, rsp_hit=0.
- Read 0x9800, responder returns rdata=0x5A with rdata_en=1 -> n_trd low clocks 3-6; rsp_rdata=0x5A, rsp_hit=1.
- Read 0xC000 with rdata_en=0 -> rsp_rdata=0xFF, rsp_hit=0.
- Read with n_wait=0 for 3 clocks starting clock 5 -> strobe low clocks 3-9, rsp_valid in clock 11, correct data captured at the final edge.
- Two requests back-to-back (write then read) -> second accepted in the rsp_valid clock; n_tsltsl high for exactly HOLD_CYC+1 clocks between the two cycles.
- Reset asserted during STROBE -> all strobes and n_tsltsl=1 immediately; no rsp_valid; next request completes normally. With MSXBUS_WAIT_TIMEOUT_EN and n_wait stuck low -> strobe released after 255 extra clocks, rsp_timeout=1.

Source files
------------

// File: rtl/msx_bus_initiator.sv
// MSX-50BUS host-side cycle generator: one read/write request in, one timed slot-bus cycle out.
// Optional: define MSXBUS_WAIT_TIMEOUT_EN to cap n_wait extension at 255 extra clocks.
module msx_bus_initiator #(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_address,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_hit,
   output logic        rsp_timeout,
   output logic        n_tsltsl,
   output logic        n_trd,
   output logic        n_twr,
   output logic [15:0] ta,
   output logic [7:0]  wdata,
   input  logic [7:0]  rdata,
   input  logic        rdata_en,
   input  logic        n_wait,
   output logic [1:0]  o_dbg_state
);
   // Handshake: a request transfers on a clk edge where req_valid && req_ready; req_ready is high only in IDLE.
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

   logic [1:0]  r_state;
   logic [7:0]  r_cnt;
   logic        r_n_wait;
   logic        r_write;
   logic        r_n_tsltsl, r_n_trd, r_n_twr;
   logic [15:0] r_ta;
   logic [7:0]  r_wdata;
   logic [7:0]  r_cap_rdata, r_rsp_rdata;
   logic        r_cap_hit, r_rsp_hit;
   logic        r_rsp_valid;
   logic        w_expired;
   logic        w_strobe_done;
   logic        w_hold_done;
   logic        w_read_ok;

   // n_wait is registered, so the strobe-end decision sees the level from the previous clock.
   assign w_strobe_done = (r_state == S_STROBE) && (r_cnt == 8'd0) && (r_n_wait || w_expired);
   assign w_hold_done   = (r_state == S_HOLD) && (r_cnt == 8'd0);
   assign w_read_ok     = !r_write && r_n_wait;

`ifdef MSXBUS_WAIT_TIMEOUT_EN
   logic [7:0] r_wcnt;
   logic       r_cap_to, r_rsp_to;

   assign w_expired   = (r_wcnt == 8'hFF);
   assign rsp_timeout = r_rsp_to;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wcnt   <= 8'd0;
         r_cap_to <= 1'b0;
         r_rsp_to <= 1'b0;
      end else begin
         if (r_state != S_STROBE)
            r_wcnt <= 8'd0;
         else if (r_cnt == 8'd0 && !r_n_wait && !w_expired)
            r_wcnt <= r_wcnt + 8'd1;
         if (w_strobe_done)
            r_cap_to <= !r_n_wait;
         if (w_hold_done)
            r_rsp_to <= r_cap_to;
      end
   end
`else
   assign w_expired   = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_n_wait    <= 1'b1;
         r_write     <= 1'b0;
         r_n_tsltsl  <= 1'b1;
         r_n_trd     <= 1'b1;
         r_n_twr     <= 1'b1;
         r_ta        <= 16'h0000;
         r_wdata     <= 8'h00;
         r_cap_rdata <= 8'hFF;
         r_cap_hit   <= 1'b0;
         r_rsp_rdata <= 8'hFF;
         r_rsp_hit   <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_n_wait    <= n_wait;
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write    <= req_write;
                  r_ta       <= req_address;
                  r_wdata    <= req_write ? req_wdata : 8'h00;
                  r_n_tsltsl <= 1'b0;
                  r_cnt      <= SETUP_LD;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == 8'd0) begin
                  r_n_trd <= r_write;
                  r_n_twr <= !r_write;
                  r_cnt   <= STROBE_LD;
                  r_state <= S_STROBE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_STROBE: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else if (w_strobe_done) begin
                  // A timed-out cycle arrives here with r_n_wait low, so it reports no data.
                  r_cap_rdata <= (w_read_ok && rdata_en) ? rdata : 8'hFF;
                  r_cap_hit   <= w_read_ok && rdata_en;
                  r_n_trd     <= 1'b1;
                  r_n_twr     <= 1'b1;
                  r_n_tsltsl  <= 1'b1;
                  r_cnt       <= HOLD_LD;
                  r_state     <= S_HOLD;
               end
            end
            default: begin
               if (w_hold_done) begin
                  r_rsp_rdata <= r_cap_rdata;
                  r_rsp_hit   <= r_cap_hit;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
         endcase
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_hit     = r_rsp_hit;
   assign n_tsltsl    = r_n_tsltsl;
   assign n_trd       = r_n_trd;
   assign n_twr       = r_n_twr;
   assign ta          = r_ta;
   assign wdata       = r_wdata;
   assign o_dbg_state = r_state;

endmodule
